ice40_ram_fifo_ctrl: RTL and testbench
======================================

Name: ice40_ram_fifo_ctrl

Overview:
Synchronous single-clock FIFO controller that drives the write and read ports of an external SB_RAM40_4K configured as 256x16 (READ_MODE/WRITE_MODE 0). It sits directly upstream of the RAM primitive and owns all of the RAM's address, enable and data signals. It exposes valid/ready push and pop interfaces to the fabric. A 2-entry output buffer hides the RAM's 1-cycle read latency and allows sustained 1 word/cycle throughput.

Parameters:
WIDTH, 16, data width; fixed to the RAM word width, other values unsupported.
AW, 8, RAM address bits used; DEPTH = 2**AW = 256.
AFULL_THRESH, 240, almost_full asserts when count >= AFULL_THRESH.

Ports:
CLK  in  1  single clock; the RAM's RCLK and WCLK are tied to CLK externally.
RESET  in  1  synchronous, active-high reset.
in_valid  in  1  push request.
in_ready  out  1  controller can accept a push.
in_data  in  16  push data.
out_valid  out  1  out_data holds the head word.
out_ready  in  1  pop request.
out_data  out  16  head word, registered.
count  out  9  words held, 0..256.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
almost_full  out  1  count >= AFULL_THRESH.
RAM_WADDR  out  11  {3'b0, wptr}.
RAM_WDATA  out  16  equals in_data.
RAM_MASK  out  16  constant 16'h0000 (active-low mask; all bits written).
RAM_WE  out  1  push fire.
RAM_WCLKE  out  1  constant 1.
RAM_RADDR  out  11  {3'b0, rptr}.
RAM_RE  out  1  read issue.
RAM_RCLKE  out  1  constant 1.
RAM_RDATA  in  16  RAM read data, valid the cycle after RAM_RE.

Behaviour:
- Reset values:
  - wptr = 0, rptr = 0, ram_cnt = 0, count = 0.
  - Output buffer empty; rd_inflight = 0.
  - out_valid = 0, out_data = 0, empty = 1, full = 0, almost_full = 0, in_ready = 1.
- Push:
  - in_ready = !full, decoded from registered count. A push at full is refused even if a pop fires in the same cycle.
  - push_fire = in_valid & in_ready.
  - RAM_WE = push_fire, combinational, same cycle. RAM_WADDR = wptr.
  - wptr increments mod 256 on push_fire.
- RAM occupancy:
  - ram_cnt counts words in RAM that have not yet been issued for read.
  - Update: +1 on push_fire, -1 on read issue.
  - A word written in cycle t is readable from cycle t+1 at the earliest. This guarantees no same-cycle read and write of the same address.
- Read issue:
  - RAM_RE = (ram_cnt > 0) & (buf_occ + rd_inflight - pop_fire < 2), where buf_occ is 0..2.
  - On issue, rptr increments mod 256.
  - rd_inflight is set on the cycle after an issue. While set, RAM_RDATA is captured into the output buffer: into the head slot if that slot is, or is becoming, empty; otherwise into the second slot.
- Pop:
  - out_valid = head slot valid. pop_fire = out_valid & out_ready.
  - On pop_fire, the second slot (or the word captured in the same cycle) moves to the head.
  - out_data holds its value while out_valid and !out_ready.
- count:
  - Update: +1 on push_fire, -1 on pop_fire, unchanged when both fire.
  - count covers RAM words, the in-flight read and buffered words; it never exceeds 256.
- Latency: push in cycle 0 into an empty FIFO -> RAM_RE in cycle 1 -> RDATA captured at the end of cycle 2 -> out_valid = 1 in cycle 3.
- Throughput: with out_ready held at 1 and continuous pushes, 1 pop per cycle in steady state.
- Wrap-around: pointers roll from 255 to 0 with no gap and no data corruption.
- Reset mid-operation: all state is cleared next cycle. Any RAM_RDATA returning from a pre-reset read is discarded. RAM contents are not cleared.
- RAM_RE = 0 and RAM_WE = 0 during the RESET cycle.

Test Plan:
- Reset, then push 16'hA5A5 in cycle 0 with out_ready = 0 -> RAM_WE = 1 and RAM_WADDR = 0 in cycle 0; RAM_RE = 1 in cycle 1; out_valid = 1 with out_data = A5A5 from cycle 3 and held; count = 1.
- Push 256 words 0..255 back-to-back with out_ready = 0 -> full = 1 and count = 256 after the last push; almost_full rises when count reaches 240; a 257th push is refused (in_ready = 0, no RAM_WE).
- From full, assert a push and a pop in the same cycle -> only the pop fires; count = 255; in_ready = 1 next cycle.
- Continuous push of an incrementing pattern for 600 cycles with out_ready = 1 -> output is in order with no gaps after the initial 3-cycle fill; wptr and rptr wrap twice; count stays at 3 or below.
- Random in_valid/out_ready at 50% for 5000 cycles -> output matches a scoreboard; RAM_RE never fires when ram_cnt = 0; the buffer never overflows.
- Assert RESET one cycle after RAM_RE with 5 words held -> next cycle count = 0, out_valid = 0, empty = 1; the late RDATA is not captured; a subsequent push is read from address 0.

Source files
------------

// File: rtl/ice40_ram_fifo_ctrl.sv
// Single-clock FIFO controller that owns the ports of an external SB_RAM40_4K (256x16).
// A 2-entry output buffer hides the RAM's 1-cycle read latency for 1 word/cycle throughput.
module ice40_ram_fifo_ctrl #(
    parameter int WIDTH        = 16,
    parameter int AW           = 8,
    parameter int AFULL_THRESH = 240
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [10:0]      RAM_WADDR,
    output logic [WIDTH-1:0] RAM_WDATA,
    output logic [WIDTH-1:0] RAM_MASK,
    output logic             RAM_WE,
    output logic             RAM_WCLKE,
    output logic [10:0]      RAM_RADDR,
    output logic             RAM_RE,
    output logic             RAM_RCLKE,
    input  logic [WIDTH-1:0] RAM_RDATA
);

    localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] C_AFULL = AFULL_THRESH[AW:0];
    localparam logic [AW:0] C_ONE   = {{AW{1'b0}}, 1'b1};

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_ram_cnt;
    logic [AW:0]      r_count;
    logic             r_inflight;
    logic             r_head_v;
    logic             r_second_v;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_second;

    logic             w_push;
    logic             w_pop;
    logic             w_re;
    logic [2:0]       w_pending;
    logic [2:0]       w_room;
    logic             w_nh_v;
    logic             w_ns_v;
    logic [WIDTH-1:0] w_nh;
    logic [WIDTH-1:0] w_ns;

    assign full        = (r_count == C_DEPTH);
    assign empty       = (r_count == '0);
    assign almost_full = (r_count >= C_AFULL);
    assign in_ready    = !full;
    assign count       = r_count;
    assign out_valid   = r_head_v;
    assign out_data    = r_head;

    assign w_push = in_valid && in_ready && !RESET;
    assign w_pop  = r_head_v && out_ready;

    // Buffered words plus the read in flight, minus this cycle's pop, must leave a free slot.
    assign w_pending = {2'b00, r_head_v} + {2'b00, r_second_v} + {2'b00, r_inflight};
    assign w_room    = 3'd2 + {2'b00, w_pop};
    assign w_re      = !RESET && (r_ram_cnt != '0) && (w_pending < w_room);

    assign RAM_WADDR = {{(11-AW){1'b0}}, r_wptr};
    assign RAM_WDATA = in_data;
    assign RAM_MASK  = '0;
    assign RAM_WE    = w_push;
    assign RAM_WCLKE = 1'b1;
    assign RAM_RADDR = {{(11-AW){1'b0}}, r_rptr};
    assign RAM_RE    = w_re;
    assign RAM_RCLKE = 1'b1;

    always_comb begin
        w_nh_v = r_head_v;
        w_nh   = r_head;
        w_ns_v = r_second_v;
        w_ns   = r_second;
        if (w_pop) begin
            w_nh_v = r_second_v;
            w_nh   = r_second;
            w_ns_v = 1'b0;
        end
        // Returning read data lands in the head if the head is free after this cycle's pop.
        if (r_inflight) begin
            if (!w_nh_v) begin
                w_nh_v = 1'b1;
                w_nh   = RAM_RDATA;
            end else begin
                w_ns_v = 1'b1;
                w_ns   = RAM_RDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_head_v   <= 1'b0;
            r_second_v <= 1'b0;
            r_head     <= '0;
            r_second   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_re) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_re) begin
                r_ram_cnt <= r_ram_cnt + C_ONE;
            end else if (!w_push && w_re) begin
                r_ram_cnt <= r_ram_cnt - C_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_ONE;
            end
            r_inflight <= w_re;
            r_head_v   <= w_nh_v;
            r_head     <= w_nh;
            r_second_v <= w_ns_v;
            r_second   <= w_ns;
        end
    end

endmodule

// File: tb/tb_ice40_ram_fifo_ctrl.sv
// Bench for ice40_ram_fifo_ctrl: behavioural RAM plus a queue-based FIFO reference model.
module tb_ice40_ram_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [8:0]  count;
    logic        empty, full, almost_full;
    logic [10:0] RAM_WADDR, RAM_RADDR;
    logic [15:0] RAM_WDATA, RAM_MASK, RAM_RDATA;
    logic        RAM_WE, RAM_WCLKE, RAM_RE, RAM_RCLKE;

    always #5 CLK = ~CLK;

    ice40_ram_fifo_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA), .RAM_MASK(RAM_MASK),
        .RAM_WE(RAM_WE), .RAM_WCLKE(RAM_WCLKE), .RAM_RADDR(RAM_RADDR),
        .RAM_RE(RAM_RE), .RAM_RCLKE(RAM_RCLKE), .RAM_RDATA(RAM_RDATA)
    );

    // SB_RAM40_4K in 256x16 mode: synchronous write, registered read data.
    logic [15:0] mem [256];
    always @(posedge CLK) begin
        if (RAM_WE && RAM_WCLKE)
            mem[RAM_WADDR[7:0]] <= (mem[RAM_WADDR[7:0]] & RAM_MASK) | (RAM_WDATA & ~RAM_MASK);
        if (RAM_RE && RAM_RCLKE)
            RAM_RDATA <= mem[RAM_RADDR[7:0]];
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    int n_push, n_re, n_pop;

    logic        obs_re, obs_we, obs_ov, obs_ir, obs_af, obs_full, obs_empty;
    logic [15:0] obs_od;
    logic [10:0] obs_waddr, obs_raddr;
    logic [8:0]  obs_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic step(input logic iv, input logic [15:0] d, input logic ordy);
        logic push, pop;
        @(negedge CLK);
        RESET = 1'b0; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        obs_re = RAM_RE; obs_we = RAM_WE; obs_ov = out_valid; obs_ir = in_ready;
        obs_af = almost_full; obs_full = full; obs_empty = empty; obs_od = out_data;
        obs_waddr = RAM_WADDR; obs_raddr = RAM_RADDR; obs_cnt = count;
        check("count", count, q.size());
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == 256);
        check("almost_full", almost_full, q.size() >= 240);
        check("in_ready", in_ready, q.size() < 256);
        check("ram_consts", {RAM_MASK, 6'b0, RAM_WCLKE, RAM_RCLKE}, 32'h0000_0003);
        push = iv && (q.size() < 256);
        check("ram_we", RAM_WE, push);
        if (push) begin
            check("ram_waddr", RAM_WADDR, n_push % 256);
            check("ram_wdata", RAM_WDATA, d);
        end
        if (RAM_RE) begin
            check("re_with_ram_empty", n_push > n_re, 1);
            check("ram_raddr", RAM_RADDR, n_re % 256);
        end
        check("buffer_bound", (n_re - n_pop) <= 2, 1);
        if (out_valid) check("valid_without_data", q.size() > 0, 1);
        pop = out_valid && ordy;
        if (pop && q.size() > 0) begin
            check("out_data", out_data, q[0]);
            void'(q.pop_front());
            n_pop++;
        end
        if (push) begin
            q.push_back(d);
            n_push++;
        end
        if (RAM_RE) n_re++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1;
        #1;
        check("we_in_reset", RAM_WE, 0);
        check("re_in_reset", RAM_RE, 0);
        q.delete();
        n_push = 0; n_re = 0; n_pop = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 600 && q.size() > 0; k++) step(1'b0, 16'h0, 1'b1);
        check("drained", q.size(), 0);
    endtask

    initial begin
        int first_ov, gaps, over;

        // Single word latency and hold.
        do_reset();
        step(1'b1, 16'hA5A5, 1'b0);
        check("t1_we", obs_we, 1);
        check("t1_waddr", obs_waddr, 0);
        step(1'b0, 16'h0, 1'b0);
        check("t1_re_c1", obs_re, 1);
        step(1'b0, 16'h0, 1'b0);
        check("t1_ov_c2", obs_ov, 0);
        step(1'b0, 16'h0, 1'b0);
        check("t1_ov_c3", obs_ov, 1);
        check("t1_od_c3", obs_od, 16'hA5A5);
        step(1'b0, 16'h0, 1'b0);
        check("t1_od_held", obs_od, 16'hA5A5);
        check("t1_count", obs_cnt, 1);

        // Fill to full, almost_full threshold, refused push.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 239) check("t2_af_239", obs_af, 0);
            if (i == 240) check("t2_af_240", obs_af, 1);
        end
        step(1'b1, 16'hBEEF, 1'b0);
        check("t2_full", obs_full, 1);
        check("t2_count", obs_cnt, 256);
        check("t2_in_ready", obs_ir, 0);
        check("t2_no_we", obs_we, 0);

        // Push and pop together at full: only the pop fires.
        step(1'b1, 16'hCAFE, 1'b1);
        check("t3_no_we", obs_we, 0);
        check("t3_pop_data", obs_od, 16'h0000);
        step(1'b0, 16'h0, 1'b0);
        check("t3_count", obs_cnt, 255);
        check("t3_in_ready", obs_ir, 1);
        drain();

        // Streaming throughput with wrap-around.
        do_reset();
        first_ov = -1; gaps = 0; over = 0;
        for (int c = 0; c < 600; c++) begin
            step(1'b1, 16'(c), 1'b1);
            if (obs_ov && first_ov < 0) first_ov = c;
            if (first_ov >= 0 && !obs_ov) gaps++;
            if (obs_cnt > 3) over++;
        end
        check("t4_first_valid", first_ov, 3);
        check("t4_gaps", gaps, 0);
        check("t4_count_over_3", over, 0);
        check("t4_wraps", n_push >= 512 && n_re >= 512, 1);
        drain();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 5000; c++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // Reset while a read is in flight.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        repeat (4) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h0105, 1'b1);
        check("t6_re_before_reset", obs_re, 1);
        check("t6_held", obs_cnt, 5);
        do_reset();
        step(1'b0, 16'h0, 1'b0);
        check("t6_count", obs_cnt, 0);
        check("t6_ov", obs_ov, 0);
        check("t6_empty", obs_empty, 1);
        step(1'b1, 16'h7777, 1'b0);
        check("t6_waddr", obs_waddr, 0);
        check("t6_late_ov", obs_ov, 0);
        step(1'b0, 16'h0, 1'b0);
        check("t6_re", obs_re, 1);
        check("t6_raddr", obs_raddr, 0);
        step(1'b0, 16'h0, 1'b0);
        check("t6_ov_c2", obs_ov, 0);
        step(1'b0, 16'h0, 1'b1);
        check("t6_ov_c3", obs_ov, 1);
        check("t6_od", obs_od, 16'h7777);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
